// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: instruction formats, base opcodes and rejection codes.
package rv32_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_OPCODE = 3'd1;
    localparam logic [2:0] ERR_FMT    = 3'd2;
    localparam logic [2:0] ERR_RANGE  = 3'd3;
    localparam logic [2:0] ERR_ALIGN  = 3'd4;

    // True when imm[31:msb] are all copies of the sign bit, i.e. the value fits msb+1 signed bits.
    function automatic logic imm_fits(input logic [31:0] imm, input int msb);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= msb && imm[i] != imm[31])
                ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer with immediate legality check.
module instr_pack
    import rv32_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        legal,
    output logic [2:0]  code
);

    always_comb begin
        instr = '0;
        case (fmt)
            FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: instr = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U: instr = {imm[31:12], rd, opcode};
            FMT_J: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: instr = '0;
        endcase
    end

    // First failing check wins; range is tested before alignment.
    always_comb begin
        code = ERR_NONE;
        if (opcode[1:0] != 2'b11)
            code = ERR_OPCODE;
        else if (fmt > FMT_J)
            code = ERR_FMT;
        else if ((fmt == FMT_I || fmt == FMT_S) && !imm_fits(imm, 11))
            code = ERR_RANGE;
        else if (fmt == FMT_B && !imm_fits(imm, 12))
            code = ERR_RANGE;
        else if (fmt == FMT_J && !imm_fits(imm, 20))
            code = ERR_RANGE;
        else if ((fmt == FMT_B || fmt == FMT_J) && imm[0])
            code = ERR_ALIGN;
        else if (fmt == FMT_U && imm[11:0] != 12'h000)
            code = ERR_ALIGN;
        legal = (code == ERR_NONE);
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: one registered output word with sequential imem address and error tracking.
module instr_encoder
    import rv32_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              full,
    output logic              err,
    output logic [2:0]        err_code,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    logic [31:0]       instr_p0;
    logic              legal_p0;
    logic [2:0]        code_p0;
    logic              vld_p1;
    logic [31:0]       instr_p1;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  sent;
    logic              full_r;
    logic              err_r;
    logic [2:0]        code_r;
    logic [7:0]        errcnt;
    logic              accept;
    logic              hs;

    instr_pack u_pack (
        .fmt    (fmt),
        .opcode (opcode),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .funct7 (funct7),
        .imm    (imm),
        .instr  (instr_p0),
        .legal  (legal_p0),
        .code   (code_p0)
    );

    assign in_ready = !full_r && (!vld_p1 || out_ready) && !clear;
    assign accept   = in_valid && in_ready;
    assign hs       = vld_p1 && out_ready;

    // p0 -> p1: packed bundle registered into the single output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            instr_p1 <= '0;
            addr     <= BASE;
            sent     <= '0;
            full_r   <= 1'b0;
            err_r    <= 1'b0;
            code_r   <= ERR_NONE;
            errcnt   <= '0;
        end else if (clear) begin
            vld_p1 <= 1'b0;
            addr   <= BASE;
            sent   <= '0;
            full_r <= 1'b0;
            err_r  <= 1'b0;
            errcnt <= '0;
        end else begin
            err_r <= 1'b0;
            if (hs) begin
                vld_p1 <= 1'b0;
                addr   <= addr + ADDR_W'(1);
                if (!full_r) begin
                    sent <= sent + CNT_W'(1);
                    if (sent == LAST)
                        full_r <= 1'b1;
                end
            end
            if (accept) begin
                if (legal_p0) begin
                    vld_p1   <= 1'b1;
                    instr_p1 <= instr_p0;
                end else begin
                    err_r  <= 1'b1;
                    code_r <= code_p0;
                    if (errcnt != 8'hFF)
                        errcnt <= errcnt + 8'd1;
                end
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_instr = instr_p1;
    assign out_addr  = addr;
    assign full      = full_r;
    assign err       = err_r;
    assign err_code  = code_r;
    assign err_count = errcnt;

endmodule
